// File: rtl/robo_limpa_tubos.sv
// robo_limpa_tubos: left-hand wall-following controller for a pipe-cleaning robot.
// Every non-halted cycle issues exactly one registered action: front, turn or remove.
module robo_limpa_tubos #(
   parameter int REMOVE_CYCLES = 3
) (
   input  logic clock,
   input  logic reset,
   input  logic head,
   input  logic left,
   input  logic under,
   input  logic barrier,
   output logic front,
   output logic turn,
   output logic remove
);
   localparam int RW = $clog2(REMOVE_CYCLES + 1);

   typedef enum logic [2:0] {SEARCH, FOLLOW, AFTER_TURN, ROTATE, REMOVE, HALT} state_t;

   state_t state_q, state_d, ret_q, ret_d, src, ev;
   logic [1:0] rot_q, rot_d;
   logic [RW-1:0] rem_q, rem_d;
   logic front_q, front_d, turn_q, turn_d, remove_q, remove_d;
   logic decide;

   always_comb begin
      state_d = state_q;
      ret_d = ret_q;
      rot_d = rot_q;
      rem_d = rem_q;
      front_d = 1'b0;
      turn_d = 1'b0;
      remove_d = 1'b0;
      src = state_q == REMOVE ? ret_q : state_q;
      // a side wall seen while searching means the wall is acquired right now
      ev = (src == SEARCH && left) ? FOLLOW : src;
      decide = state_q inside {SEARCH, FOLLOW, AFTER_TURN} ||
               (state_q == REMOVE && rem_q == RW'(REMOVE_CYCLES));
      if (state_q == ROTATE) begin
         turn_d = 1'b1;
         rot_d = rot_q - 2'd1;
         if (rot_q == 2'd1) state_d = FOLLOW;
      end else if (state_q == REMOVE && !decide) begin
         remove_d = 1'b1;
         rem_d = rem_q + 1'b1;
      end
      if (decide) begin
         rem_d = '0;
         if (barrier) begin
            remove_d = 1'b1;
            rem_d = RW'(1);
            ret_d = src;
            state_d = REMOVE_CYCLES > 1 ? REMOVE : src;
         end else if (ev == FOLLOW && !left) begin
            turn_d = 1'b1;
            state_d = AFTER_TURN;
         end else if (!head) begin
            front_d = 1'b1;
            state_d = ev == AFTER_TURN ? FOLLOW : ev;
         end else begin
            // right turn: this turn plus two more from ROTATE
            turn_d = 1'b1;
            rot_d = 2'd2;
            state_d = ROTATE;
         end
      end
      if (under) begin
         state_d = HALT;
         front_d = 1'b0;
         turn_d = 1'b0;
         remove_d = 1'b0;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= SEARCH;
         ret_q <= SEARCH;
         rot_q <= '0;
         rem_q <= '0;
         front_q <= 1'b0;
         turn_q <= 1'b0;
         remove_q <= 1'b0;
      end else begin
         state_q <= state_d;
         ret_q <= ret_d;
         rot_q <= rot_d;
         rem_q <= rem_d;
         front_q <= front_d;
         turn_q <= turn_d;
         remove_q <= remove_d;
      end
   end

   assign front = front_q;
   assign turn = turn_q;
   assign remove = remove_q;
endmodule

// File: tb/tb_robo_limpa_tubos.sv
// tb_robo_limpa_tubos: directed scenarios plus randomized run against an action-queue model.
module tb_robo_limpa_tubos;
   localparam int RC = 3;
   localparam logic [2:0] N = 3'b000, F = 3'b100, T = 3'b010, R = 3'b001;

   logic clock = 1'b0, reset = 1'b0, head = 1'b0, left = 1'b0, under = 1'b0, barrier = 1'b0;
   logic front, turn, remove;
   int checks = 0, errors = 0;

   bit m_halt, m_acq, m_jl;
   logic [2:0] m_q[$];
   logic [2:0] exp_act;

   robo_limpa_tubos #(.REMOVE_CYCLES(RC)) dut (
      .clock(clock), .reset(reset), .head(head), .left(left), .under(under),
      .barrier(barrier), .front(front), .turn(turn), .remove(remove)
   );

   always #5 clock = ~clock;

   // Pending actions queue: a right turn queues two more turns, a removal queues the rest.
   task automatic model(input logic [4:0] s);
      bit r, h, l, u, b, fol;
      {r, h, l, u, b} = s;
      if (r) begin
         m_halt = 0; m_acq = 0; m_jl = 0; m_q.delete(); exp_act = N;
      end else if (m_halt || u) begin
         m_halt = 1; m_q.delete(); exp_act = N;
      end else if (m_q.size() > 0) begin
         exp_act = m_q.pop_front();
         if (exp_act == T) m_acq = 1;
      end else if (b) begin
         exp_act = R;
         repeat (RC - 1) m_q.push_back(R);
      end else begin
         fol = m_acq || l;
         if (m_jl) begin
            m_jl = 0; m_acq = 1;
            if (!h) exp_act = F;
            else begin exp_act = T; m_q.push_back(T); m_q.push_back(T); end
         end else if (fol && !l) begin
            exp_act = T; m_jl = 1; m_acq = 1;
         end else if (!h) begin
            exp_act = F; m_acq = fol;
         end else begin
            exp_act = T; m_acq = 1; m_q.push_back(T); m_q.push_back(T);
         end
      end
   endtask

   task automatic drive(input logic [4:0] s);
      {reset, head, left, under, barrier} = s;
      @(posedge clock);
      #1;
      model(s);
   endtask

   task automatic run_table(input string name, input logic [7:0] t[$]);
      foreach (t[i]) begin
         drive(t[i][7:3]);
         checks++;
         if ({front, turn, remove} !== t[i][2:0]) begin
            errors++;
            $display("FAIL %s step %0d: got ftr=%b want ftr=%b", name, i, {front, turn, remove}, t[i][2:0]);
         end
      end
   endtask

   task automatic test_reset;
      for (int i = 0; i < 2; i++) begin
         drive({1'b1, 4'($urandom)});
         checks++;
         if ({front, turn, remove} !== N) begin
            errors++;
            $display("FAIL reset cycle %0d: got ftr=%b want ftr=%b", i, {front, turn, remove}, N);
         end
      end
      drive(5'b00000);
      checks++;
      if ({front, turn, remove} !== F) begin
         errors++;
         $display("FAIL reset_release: got ftr=%b want ftr=%b", {front, turn, remove}, F);
      end
   endtask

   task automatic test_search_wall;
      logic [7:0] t[$];
      t = '{{5'b10000, N}, {5'b00000, F}, {5'b00000, F}, {5'b00000, F}, {5'b01000, T},
            {5'b01100, T}, {5'b00000, T}, {5'b00100, F}};
      run_table("search_wall", t);
   endtask

   task automatic test_corridor;
      logic [7:0] t[$];
      t = '{{5'b00100, F}, {5'b00000, T}, {5'b00000, F}, {5'b00100, F}, {5'b00100, F}};
      run_table("corridor", t);
   endtask

   task automatic test_trash;
      logic [7:0] t[$];
      t = '{{5'b01101, R}, {5'b01101, R}, {5'b00001, R}, {5'b00100, F}};
      run_table("trash", t);
   endtask

   task automatic test_terminal;
      logic [7:0] t[$];
      t = '{{5'b01100, T}, {5'b00010, N}};
      run_table("terminal", t);
      for (int i = 0; i < 12; i++) begin
         drive({1'b0, 4'($urandom)});
         checks++;
         if ({front, turn, remove} !== N) begin
            errors++;
            $display("FAIL halted cycle %0d: got ftr=%b want ftr=%b", i, {front, turn, remove}, N);
         end
      end
      t = '{{5'b10000, N}, {5'b00000, F}, {5'b01000, T}};
      run_table("terminal_recover", t);
   endtask

   task automatic test_reset_mid_remove;
      logic [7:0] t[$];
      t = '{{5'b10000, N}, {5'b00001, R}, {5'b10001, N}, {5'b00001, R}, {5'b00001, R},
            {5'b00001, R}, {5'b00000, F}};
      run_table("reset_mid_remove", t);
   endtask

   task automatic test_random;
      drive(5'b10000);
      for (int i = 0; i < 1500; i++) begin
         drive({$urandom_range(59) == 0, 2'($urandom), $urandom_range(49) == 0, $urandom_range(5) == 0});
         checks++;
         if ({front, turn, remove} !== exp_act) begin
            errors++;
            $display("FAIL random cycle %0d: got ftr=%b want ftr=%b", i, {front, turn, remove}, exp_act);
         end
      end
   endtask

   initial begin
      test_reset;
      test_search_wall;
      test_corridor;
      test_trash;
      test_terminal;
      test_reset_mid_remove;
      test_random;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
